// File: rtl/fir_coeff_loader.sv
// Coefficient loader for the polyphase FIR: streams a full coefficient set into a
// shadow bank and then commits the whole bank to the active vector in one cycle.

module fir_coeff_slot #(
    parameter int COEFF_WIDTH = 21,
    parameter int CNT_WIDTH   = 8,
    parameter int IDX         = 0
) (
    input  logic                   clk,
    input  logic                   wr_en,
    input  logic [CNT_WIDTH-1:0]   idx,
    input  logic [COEFF_WIDTH-1:0] wdata,
    output logic [COEFF_WIDTH-1:0] word
);
    logic [COEFF_WIDTH-1:0] word_q;

    // Shadow storage is never reset: a commit only follows a full in-order write.
    always_ff @(posedge clk) begin
        if (wr_en && (idx == CNT_WIDTH'(IDX)))
            word_q <= wdata;
    end

    assign word = word_q;
endmodule

module fir_coeff_loader #(
    parameter int NUM_COEFFS  = 90,
    parameter int COEFF_WIDTH = 21,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              cfg_valid,
    output logic                              cfg_ready,
    input  logic [COEFF_WIDTH-1:0]            cfg_data,
    input  logic                              cfg_last,
    input  logic                              cfg_abort,
    input  logic                              swap_en,
    output logic [NUM_COEFFS*COEFF_WIDTH-1:0] coeffs,
    output logic                              coeff_update,
    output logic                              pending,
    output logic                              err_short,
    output logic                              err_long
);
    localparam int                   NW       = NUM_COEFFS * COEFF_WIDTH;
    localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(NUM_COEFFS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_PEND
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   idx_q, idx_d;
    logic [NW-1:0]          coeffs_q, coeffs_d;
    logic [NW-1:0]          shadow_flat;
    logic                   update_q, update_d;
    logic                   pending_q, pending_d;
    logic                   short_q, short_d;
    logic                   long_q, long_d;
    logic                   xfer, at_end, wr_en, commit;

    assign cfg_ready = (state_q != S_PEND);
    assign xfer      = cfg_valid & cfg_ready & ~cfg_abort;
    assign at_end    = (idx_q == LAST_IDX);

    for (genvar g = 0; g < NUM_COEFFS; g++) begin : g_slot
        fir_coeff_slot #(
            .COEFF_WIDTH (COEFF_WIDTH),
            .CNT_WIDTH   (CNT_WIDTH),
            .IDX         (g)
        ) u_slot (
            .clk   (clk),
            .wr_en (wr_en),
            .idx   (idx_q),
            .wdata (cfg_data),
            .word  (shadow_flat[g*COEFF_WIDTH +: COEFF_WIDTH])
        );
    end

    // IDLE is LOAD with index 0, so both share one transfer decision.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        wr_en    = 1'b0;
        commit   = 1'b0;
        short_d  = 1'b0;
        long_d   = 1'b0;
        if (cfg_abort) begin
            state_d = S_IDLE;
            idx_d   = '0;
        end else begin
            case (state_q)
                S_IDLE, S_LOAD: begin
                    if (xfer) begin
                        idx_d   = '0;
                        state_d = S_IDLE;
                        if (cfg_last && at_end) begin
                            wr_en   = 1'b1;
                            state_d = S_PEND;
                        end else if (cfg_last) begin
                            short_d = 1'b1;
                        end else if (at_end) begin
                            long_d  = 1'b1;
                        end else begin
                            wr_en   = 1'b1;
                            idx_d   = idx_q + CNT_WIDTH'(1);
                            state_d = S_LOAD;
                        end
                    end
                end
                S_PEND: begin
                    if (swap_en) begin
                        commit  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        coeffs_d  = commit ? shadow_flat : coeffs_q;
        update_d  = commit;
        pending_d = (state_d == S_PEND);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            coeffs_q  <= '0;
            update_q  <= 1'b0;
            pending_q <= 1'b0;
            short_q   <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            coeffs_q  <= coeffs_d;
            update_q  <= update_d;
            pending_q <= pending_d;
            short_q   <= short_d;
            long_q    <= long_d;
        end
    end

    assign coeffs       = coeffs_q;
    assign coeff_update = update_q;
    assign pending      = pending_q;
    assign err_short    = short_q;
    assign err_long     = long_q;
endmodule
